// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage: bus widths, ALU opcodes,
// FSM states and the bypass-select helper used for every source operand.
package exe_stage_pkg;

   localparam int RegBus         = 32;
   localparam int RegAddrBus     = 5;
   localparam int AluCtrl        = 4;
   localparam int MUL_CYCLES_DEF = 32;

   typedef enum logic [AluCtrl-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_ROTR = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10,
      ALU_MUL  = 4'd11,
      ALU_MOVB = 4'd12
   } alu_op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } exe_state_e;

   // MEM bypass is younger than WB, so it wins when both match.
   function automatic logic [RegBus-1:0] fwd_sel(
      input logic [RegAddrBus-1:0] addr,
      input logic [RegBus-1:0]     rf,
      input logic                  mem_en,
      input logic [RegAddrBus-1:0] mem_addr,
      input logic [RegBus-1:0]     mem_data,
      input logic                  wb_en,
      input logic [RegAddrBus-1:0] wb_addr,
      input logic [RegBus-1:0]     wb_data
   );
      if (mem_en && (mem_addr == addr)) return mem_data;
      if (wb_en && (wb_addr == addr))   return wb_data;
      return rf;
   endfunction

endpackage

// File: rtl/exe_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low word kept.
// product_o is valid combinationally while last_o is high.
module exe_mul
   import exe_stage_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [RegBus-1:0] a_i,
   input  logic [RegBus-1:0] b_i,
   output logic              last_o,
   output logic [RegBus-1:0] product_o
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic              busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RegBus-1:0] mcand_q, mcand_d;
   logic [RegBus-1:0] mplier_q, mplier_d;
   logic [RegBus-1:0] acc_q, acc_d;
   logic [RegBus-1:0] step_sum;

   assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_o    = busy_q && (cnt_q == CW'(MUL_CYCLES - 1));
   assign product_o = step_sum;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (abort_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (busy_q) begin
         acc_d    = step_sum;
         mcand_d  = {mcand_q[RegBus-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[RegBus-1:1]};
         if (last_o) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand bypass, single-cycle ALU, multi-cycle MUL sequencing
// and the EXE/MEM pipeline register. stall_o holds the front end during MUL.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid_i,
   input  logic                  flush_i,
   input  logic [RegAddrBus-1:0] reg1_addr_i,
   input  logic [RegAddrBus-1:0] reg2_addr_i,
   input  logic [RegAddrBus-1:0] reg3_addr_i,
   input  logic [RegBus-1:0]     reg1_i,
   input  logic [RegBus-1:0]     reg2_i,
   input  logic [RegBus-1:0]     reg3_i,
   input  logic [RegBus-1:0]     imm_i,
   input  logic [AluCtrl-1:0]    alu_ctrl_i,
   input  logic                  src_imm_reg_i,
   input  logic                  src_mem_alu_i,
   input  logic                  src_din_i,
   input  logic                  wb_en_i,
   input  logic                  mem_fwd_en_i,
   input  logic [RegAddrBus-1:0] mem_fwd_addr_i,
   input  logic [RegBus-1:0]     mem_fwd_data_i,
   input  logic                  wb_fwd_en_i,
   input  logic [RegAddrBus-1:0] wb_fwd_addr_i,
   input  logic [RegBus-1:0]     wb_fwd_data_i,
   output logic                  exe_valid_o,
   output logic [RegBus-1:0]     alu_result_o,
   output logic [RegBus-1:0]     store_data_o,
   output logic [RegAddrBus-1:0] dst_addr_o,
   output logic                  wb_en_o,
   output logic                  mem_to_reg_o,
   output logic                  mem_we_o,
   output logic                  stall_o
);

   logic [RegBus-1:0] op_a, op_b, fwd_b, fwd_c, alu_res;
   logic [4:0]        shamt;
   logic              is_mul;

   assign op_a   = fwd_sel(reg1_addr_i, reg1_i, mem_fwd_en_i, mem_fwd_addr_i, mem_fwd_data_i,
                           wb_fwd_en_i, wb_fwd_addr_i, wb_fwd_data_i);
   assign fwd_b  = fwd_sel(reg2_addr_i, reg2_i, mem_fwd_en_i, mem_fwd_addr_i, mem_fwd_data_i,
                           wb_fwd_en_i, wb_fwd_addr_i, wb_fwd_data_i);
   assign fwd_c  = fwd_sel(reg3_addr_i, reg3_i, mem_fwd_en_i, mem_fwd_addr_i, mem_fwd_data_i,
                           wb_fwd_en_i, wb_fwd_addr_i, wb_fwd_data_i);
   assign op_b   = src_imm_reg_i ? imm_i : fwd_b;
   assign shamt  = op_b[4:0];
   assign is_mul = (alu_ctrl_i == ALU_MUL);

   logic [2*RegBus-1:0] rot_w;
   assign rot_w = {op_a, op_a} >> shamt;

   always_comb begin
      alu_res = '0;
      case (alu_ctrl_i)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_ROTR: alu_res = rot_w[RegBus-1:0];
         ALU_SLT:  alu_res = {{(RegBus-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(RegBus-1){1'b0}}, (op_a < op_b)};
         ALU_MOVB: alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

   // MUL sequencing
   exe_state_e        state_q, state_d;
   logic              mul_start, mul_abort, mul_last;
   logic [RegBus-1:0] mul_prod;

   exe_mul #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .abort_i   (mul_abort),
      .a_i       (op_a),
      .b_i       (op_b),
      .last_o    (mul_last),
      .product_o (mul_prod)
   );

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      mul_abort = 1'b0;
      stall_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!flush_i && id_valid_i && is_mul) begin
               state_d   = ST_MUL_BUSY;
               mul_start = 1'b1;
               stall_o   = 1'b1;
            end
         end
         ST_MUL_BUSY: begin
            if (flush_i) begin
               state_d   = ST_IDLE;
               mul_abort = 1'b1;
            end else if (mul_last) begin
               state_d = ST_IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!rst) stall_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Control and store data of the in-flight MUL, captured at accept
   logic [RegAddrBus-1:0] mdst_q;
   logic [RegBus-1:0]     msd_q;
   logic                  mwb_q, mm2r_q, mwe_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mdst_q <= '0;
         msd_q  <= '0;
         mwb_q  <= 1'b0;
         mm2r_q <= 1'b0;
         mwe_q  <= 1'b0;
      end else if (mul_start) begin
         mdst_q <= reg3_addr_i;
         msd_q  <= fwd_c;
         mwb_q  <= wb_en_i;
         mm2r_q <= src_mem_alu_i;
         mwe_q  <= src_din_i;
      end
   end

   // EXE/MEM register; bubbles clear valid and side-effect controls only
   logic                  vld_q, vld_d, wb_q, wb_d, m2r_q, m2r_d, we_q, we_d;
   logic [RegBus-1:0]     res_q, res_d, sd_q, sd_d;
   logic [RegAddrBus-1:0] dst_q, dst_d;

   always_comb begin
      vld_d = 1'b0;
      wb_d  = 1'b0;
      m2r_d = 1'b0;
      we_d  = 1'b0;
      res_d = res_q;
      sd_d  = sd_q;
      dst_d = dst_q;
      if (flush_i) begin
         vld_d = 1'b0;
      end else if (state_q == ST_MUL_BUSY) begin
         if (mul_last) begin
            vld_d = 1'b1;
            res_d = mul_prod;
            sd_d  = msd_q;
            dst_d = mdst_q;
            wb_d  = mwb_q;
            m2r_d = mm2r_q;
            we_d  = mwe_q;
         end
      end else if (!mul_start) begin
         vld_d = id_valid_i;
         res_d = alu_res;
         sd_d  = fwd_c;
         dst_d = reg3_addr_i;
         wb_d  = id_valid_i && wb_en_i;
         m2r_d = id_valid_i && src_mem_alu_i;
         we_d  = id_valid_i && src_din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= 1'b0;
         wb_q  <= 1'b0;
         m2r_q <= 1'b0;
         we_q  <= 1'b0;
         res_q <= '0;
         sd_q  <= '0;
         dst_q <= '0;
      end else begin
         vld_q <= vld_d;
         wb_q  <= wb_d;
         m2r_q <= m2r_d;
         we_q  <= we_d;
         res_q <= res_d;
         sd_q  <= sd_d;
         dst_q <= dst_d;
      end
   end

   assign exe_valid_o  = vld_q;
   assign alu_result_o = res_q;
   assign store_data_o = sd_q;
   assign dst_addr_o   = dst_q;
   assign wb_en_o      = wb_q;
   assign mem_to_reg_o = m2r_q;
   assign mem_we_o     = we_q;

endmodule
